debug_frame_tx: RTL

//  Parametrised telemetry/heartbeat framer for the debug UART. Sends a framed snapshot of NUM_CH channels
//  to the UART TX byte interface. A frame starts on either of two events:
//  - idle-watchdog expiry;
//  - a trigger byte received on the UART RX interface.

---
 rtl/debug_frame_tx_pkg.sv | 23 ++
 rtl/debug_frame_tx_payload_mux.sv | 35 +++
 rtl/debug_frame_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/debug_frame_tx_pkg.sv
// Shared debug_* definitions: frame marker/code defaults, 3-bit FSM encoding, bytes-per-channel helper.
package debug_frame_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_START = 3'd1,
    S_CODE  = 3'd2,
    S_LEN   = 3'd3,
    S_PAY   = 3'd4,
    S_CK    = 3'd5,
    S_DONE  = 3'd6
  } dbg_state_e;

  localparam logic [7:0] DBG_START_BYTE = 8'h68;
  localparam logic [7:0] DBG_WDOG_CODE  = 8'h65;
  localparam logic [7:0] DBG_CMD_CODE   = 8'h63;
  localparam logic [7:0] DBG_TRIG_BYTE  = 8'h3F;

  function automatic int dbg_bpc(input int data_w);
    return (data_w + 7) / 8;
  endfunction

endpackage

// File: rtl/debug_frame_tx_payload_mux.sv
// dbg_payload_mux: combinational byte picker over the channel snapshot, channel 0 first, MSB first,
// each channel zero-extended to a whole number of bytes.
module dbg_payload_mux
  import debug_frame_tx_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16
) (
  input  logic [NUM_CH*DATA_W-1:0] i_snap,
  input  logic [7:0]               i_idx,
  output logic [7:0]               o_byte
);

  localparam int BPC = dbg_bpc(DATA_W);
  localparam int LEN = NUM_CH * BPC;

  logic [BPC*8-1:0] w_chpad [NUM_CH];
  logic [7:0]       w_bytes [LEN];

  genvar c, b;
  for (c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_chpad[c] = (BPC*8)'(i_snap[c*DATA_W +: DATA_W]);
    for (b = 0; b < BPC; b++) begin : g_byte
      assign w_bytes[c*BPC+b] = w_chpad[c][(BPC-1-b)*8 +: 8];
    end
  end

  always_comb begin
    o_byte = 8'h00;
    for (int k = 0; k < LEN; k++) begin
      if (i_idx == 8'(k)) o_byte = w_bytes[k];
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// debug_frame_tx: watchdog/RX-triggered snapshot framer to the UART TX; o_wvalid one cycle after start, stalls on i_wready.
// Defining DBG_CHECKSUM_EN appends an XOR checksum byte over CODE, LEN and payload.
module debug_frame_tx
  import debug_frame_tx_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          DATA_W     = 16,
  parameter logic [31:0] PERIOD     = 32'h59682F00,
  parameter logic [7:0]  START_BYTE = DBG_START_BYTE,
  parameter logic [7:0]  WDOG_CODE  = DBG_WDOG_CODE,
  parameter logic [7:0]  CMD_CODE   = DBG_CMD_CODE,
  parameter logic [7:0]  TRIG_BYTE  = DBG_TRIG_BYTE
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_rdata,
  input  logic                     i_rready,
  output logic                     o_rreq,
  input  logic                     i_wready,
  output logic [7:0]               o_wdata,
  output logic                     o_wvalid,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int         BPC  = dbg_bpc(DATA_W);
  localparam int         LEN  = NUM_CH * BPC;
  localparam logic [7:0] LEN8 = 8'(LEN);
  localparam logic [7:0] LAST = 8'(LEN - 1);

  if (LEN > 255) begin : g_len_err
    $error("debug_frame_tx: NUM_CH*BPC exceeds 255 payload bytes");
  end

  dbg_state_e              r_state;
  logic [31:0]             r_wdog;
  logic                    r_pending;
  logic [7:0]              r_code;
  logic [7:0]              r_idx;
  logic [NUM_CH*DATA_W-1:0] r_snap;
  logic                    r_rreq;
  logic                    r_wvalid;
  logic [7:0]              r_wdata;
  logic                    r_busy;
  logic                    r_done;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]              r_ck;
`endif

  logic       w_rx_take;
  logic       w_rx_trig;
  logic       w_accept;
  logic       w_cmd;
  logic       w_start;
  logic [7:0] w_mux_idx;
  logic [7:0] w_pay_byte;

  // One pop per byte: o_rreq high blocks re-inspection of the byte being popped.
  assign w_rx_take = i_rready & ~r_rreq;
  assign w_rx_trig = w_rx_take & (i_rdata == TRIG_BYTE);
  assign w_accept  = r_wvalid & i_wready;
  assign w_cmd     = w_rx_trig | r_pending;
  assign w_start   = (r_state == IDLE) & (w_cmd | (r_wdog == 32'd0));
  assign w_mux_idx = (r_state == S_PAY) ? r_idx + 8'd1 : 8'd0;

  dbg_payload_mux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_mux (
    .i_snap (r_snap),
    .i_idx  (w_mux_idx),
    .o_byte (w_pay_byte)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_wdog    <= PERIOD - 32'd1;
      r_pending <= 1'b0;
      r_code    <= 8'h00;
      r_idx     <= 8'h00;
      r_snap    <= '0;
      r_rreq    <= 1'b0;
      r_wvalid  <= 1'b0;
      r_wdata   <= 8'h00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef DBG_CHECKSUM_EN
      r_ck      <= 8'h00;
`endif
    end else begin
      r_rreq <= w_rx_take;
      r_done <= 1'b0;
      if (r_state != IDLE)          r_wdog <= PERIOD - 32'd1;
      else if (r_wdog != 32'd0)     r_wdog <= r_wdog - 32'd1;
      if (w_rx_trig && r_state != IDLE) r_pending <= 1'b1;

      case (r_state)
        IDLE: if (w_start) begin
          r_state   <= S_START;
          r_busy    <= 1'b1;
          r_wvalid  <= 1'b1;
          r_wdata   <= START_BYTE;
          r_code    <= w_cmd ? CMD_CODE : WDOG_CODE;
          r_snap    <= i_ch_data;
          r_pending <= 1'b0;
        end
        S_START: if (w_accept) begin
          r_state <= S_CODE;
          r_wdata <= r_code;
`ifdef DBG_CHECKSUM_EN
          r_ck    <= r_code ^ LEN8;
`endif
        end
        S_CODE: if (w_accept) begin
          r_state <= S_LEN;
          r_wdata <= LEN8;
        end
        S_LEN: if (w_accept) begin
          r_state <= S_PAY;
          r_idx   <= 8'h00;
          r_wdata <= w_pay_byte;
        end
        S_PAY: if (w_accept) begin
`ifdef DBG_CHECKSUM_EN
          r_ck <= r_ck ^ r_wdata;
`endif
          if (r_idx == LAST) begin
`ifdef DBG_CHECKSUM_EN
            r_state  <= S_CK;
            r_wdata  <= r_ck ^ r_wdata;
`else
            r_state  <= S_DONE;
            r_wvalid <= 1'b0;
            r_done   <= 1'b1;
`endif
          end else begin
            r_idx   <= r_idx + 8'd1;
            r_wdata <= w_pay_byte;
          end
        end
`ifdef DBG_CHECKSUM_EN
        S_CK: if (w_accept) begin
          r_state  <= S_DONE;
          r_wvalid <= 1'b0;
          r_done   <= 1'b1;
        end
`endif
        S_DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state  <= IDLE;
          r_busy   <= 1'b0;
          r_wvalid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rreq       = r_rreq;
  assign o_wvalid     = r_wvalid;
  assign o_wdata      = r_wdata;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;

endmodule
